// File: rtl/clk_rst_gen.sv
// clk_rst_gen: reset sequencer plus power-of-two clock-enable divider.
// cpu_rst releases RST_HOLD cycles after a two-flop synchronised reset release;
// clk_en pulses once every 2^min(sel, MAX_SHIFT) cycles, and ticks counts the pulses.
// Optional single-step mode is compiled in when the macro STEP_EN is defined.
module clk_rst_gen #(
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned MAX_SHIFT = 4,
  parameter int unsigned RST_HOLD  = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] clk_choose,
  input  logic             step_mode,
  input  logic             step_btn,
  output logic             cpu_rst,
  output logic             clk_en,
  output logic [SEL_W-1:0] sel_cur,
  output logic [CNT_W-1:0] ticks
);

  localparam int unsigned DIV_W  = (MAX_SHIFT > 0) ? MAX_SHIFT : 1;
  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(MAX_SHIFT);

  logic              rst_s1;
  logic              rst_s2;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;

  logic [SEL_W-1:0]  sel_s1;
  logic [SEL_W-1:0]  sel_s2;
  logic [SEL_W-1:0]  sel_sat;

  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_last;
  logic [DIV_W-1:0]  div_nxt;
  logic              en_nxt;
  logic [SEL_W-1:0]  sel_nxt;
  logic [CNT_W-1:0]  ticks_nxt;

  logic              step_hold;
  logic              step_exit;
  logic              btn_rise;

  // Reset synchroniser: asynchronous assertion, synchronous release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_s1 <= 1'b0;
      rst_s2 <= 1'b0;
    end else begin
      rst_s1 <= 1'b1;
      rst_s2 <= rst_s1;
    end
  end

  // Last hold cycle: cpu_rst rises on this edge.
  assign hold_done = rst_s2 && !cpu_rst && (hold_cnt == HOLD_W'(RST_HOLD - 1));

  // Core reset hold counter after the synchronised release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
      cpu_rst  <= 1'b0;
    end else if (rst_s2 && !cpu_rst) begin
      if (hold_done) begin
        cpu_rst <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  // Select synchroniser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_s1 <= '0;
      sel_s2 <= '0;
    end else begin
      sel_s1 <= clk_choose;
      sel_s2 <= sel_s1;
    end
  end

  assign sel_sat  = (32'(sel_s2) > MAX_SHIFT) ? SEL_MAX : sel_s2;
  assign div_last = DIV_W'((32'd1 << sel_cur) - 32'd1);

`ifdef STEP_EN
  logic step_s1;
  logic step_s2;
  logic step_q;
  logic btn_s1;
  logic btn_s2;
  logic btn_q;

  // Step-mode and button synchronisers plus one-cycle history for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_q  <= 1'b0;
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      btn_q   <= 1'b0;
    end else begin
      step_s1 <= step_mode;
      step_s2 <= step_s1;
      step_q  <= step_s2;
      btn_s1  <= step_btn;
      btn_s2  <= btn_s1;
      btn_q   <= btn_s2;
    end
  end

  assign step_hold = step_s2;
  assign step_exit = !step_s2 && step_q;
  assign btn_rise  = btn_s2 && !btn_q;
`else
  logic unused_step;

  assign unused_step = step_mode ^ step_btn;
  assign step_hold   = 1'b0;
  assign step_exit   = 1'b0;
  assign btn_rise    = 1'b0;
`endif

  // Divider next state: latch select at release, on wrap, or on leaving step mode.
  always_comb begin
    div_nxt   = div_cnt;
    en_nxt    = 1'b0;
    sel_nxt   = sel_cur;
    ticks_nxt = ticks;
    if (hold_done) begin
      div_nxt = '0;
      sel_nxt = sel_sat;
    end else if (cpu_rst) begin
      if (step_hold) begin
        div_nxt = '0;
        en_nxt  = btn_rise;
      end else if (step_exit) begin
        div_nxt = '0;
        sel_nxt = sel_sat;
      end else if (div_cnt == div_last) begin
        div_nxt = '0;
        en_nxt  = 1'b1;
        sel_nxt = sel_sat;
      end else begin
        div_nxt = div_cnt + DIV_W'(1);
      end
    end
    if (en_nxt) begin
      ticks_nxt = ticks + CNT_W'(1);
    end
  end

  // Divider, enable, applied select and pulse counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      clk_en  <= 1'b0;
      sel_cur <= '0;
      ticks   <= '0;
    end else begin
      div_cnt <= div_nxt;
      clk_en  <= en_nxt;
      sel_cur <= sel_nxt;
      ticks   <= ticks_nxt;
    end
  end

endmodule

// File: tb/tb_clk_rst_gen.sv
// Bench for clk_rst_gen: event-scheduled reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_clk_rst_gen;

  localparam int SEL_W     = 3;
  localparam int MAX_SHIFT = 4;
  localparam int RST_HOLD  = 4;
  localparam int CNT_W     = 8;
`ifdef STEP_EN
  localparam bit STEP_ON = 1'b1;
`else
  localparam bit STEP_ON = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [SEL_W-1:0] clk_choose;
  logic             step_mode;
  logic             step_btn;
  logic             cpu_rst;
  logic             clk_en;
  logic [SEL_W-1:0] sel_cur;
  logic [CNT_W-1:0] ticks;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_on = 1'b0;

  clk_rst_gen #(
    .SEL_W(SEL_W), .MAX_SHIFT(MAX_SHIFT), .RST_HOLD(RST_HOLD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .clk_choose(clk_choose), .step_mode(step_mode),
    .step_btn(step_btn), .cpu_rst(cpu_rst), .clk_en(clk_en),
    .sel_cur(sel_cur), .ticks(ticks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cpu_rst rises RST_HOLD+2 edges after release; pulses are
  // scheduled as absolute edge numbers, one period after each (re)start.
  int     hi_cnt;
  longint edge_no;
  longint next_pulse;
  bit     m_cpu, m_en;
  int     m_sel, m_ticks;
  int     sel_pipe[2];
  bit     step_pipe[2];
  bit     btn_pipe[2];
  bit     prev_step, prev_btn;

  function automatic int sat_sel(input int s);
    return (s > MAX_SHIFT) ? MAX_SHIFT : s;
  endfunction

  task automatic restart(input int s);
    m_sel      = sat_sel(s);
    next_pulse = edge_no + (longint'(1) << m_sel);
  endtask

  task automatic model_edge();
    int u_sel;
    bit u_step, u_btn;
    if (!rst) begin
      hi_cnt = 0; m_cpu = 0; m_en = 0; m_sel = 0; m_ticks = 0;
      sel_pipe[0] = 0; sel_pipe[1] = 0;
      step_pipe[0] = 0; step_pipe[1] = 0;
      btn_pipe[0] = 0; btn_pipe[1] = 0;
      prev_step = 0; prev_btn = 0;
    end else begin
      edge_no++;
      u_sel  = sel_pipe[0];  sel_pipe[0]  = sel_pipe[1];  sel_pipe[1]  = int'(clk_choose);
      u_step = step_pipe[0]; step_pipe[0] = step_pipe[1]; step_pipe[1] = step_mode;
      u_btn  = btn_pipe[0];  btn_pipe[0]  = btn_pipe[1];  btn_pipe[1]  = step_btn;
      m_en = 0;
      if (!m_cpu) begin
        hi_cnt++;
        if (hi_cnt == RST_HOLD + 2) begin
          m_cpu = 1;
          restart(u_sel);
        end
      end else if (STEP_ON && u_step) begin
        m_en = u_btn && !prev_btn;
      end else if (STEP_ON && prev_step) begin
        restart(u_sel);
      end else if (edge_no == next_pulse) begin
        m_en = 1;
        restart(u_sel);
      end
      if (m_en) m_ticks = (m_ticks + 1) % (1 << CNT_W);
      prev_step = u_step;
      prev_btn  = u_btn;
    end
  endtask

  // Per-cycle compare against the model, sampled 1 time unit after the edge.
  initial begin
    edge_no = 0;
    forever begin
      @(posedge clk);
      model_edge();
      #1;
      if (chk_on) begin
        check("cpu_rst", longint'(cpu_rst), longint'(m_cpu));
        check("clk_en",  longint'(clk_en),  longint'(m_en));
        check("sel_cur", longint'(sel_cur), longint'(m_sel));
        check("ticks",   longint'(ticks),   longint'(m_ticks));
      end
    end
  end

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_cpu_rst(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_rst && n < 50);
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!clk_en && n < 100);
  endtask

  initial begin
    int n;
    int pulses;
    rst = 1'b0; clk_choose = 3'd7; step_mode = 1'b0; step_btn = 1'b0;
    chk_on = 1'b1;

    // Reset state and release timing.
    repeat (10) @(negedge clk);
    check("rst_cpu_rst", longint'(cpu_rst), 0);
    check("rst_clk_en",  longint'(clk_en), 0);
    check("rst_ticks",   longint'(ticks), 0);
    check("rst_sel_cur", longint'(sel_cur), 0);
    clk_choose = 3'd0;
    rst = 1'b1;
    wait_cpu_rst(n);
    check("release_latency", n, 6);

    // Ratio 1: pulse every cycle, ticks counts and wraps at 2^CNT_W.
    check("ratio1_ticks0", longint'(ticks), 0);
    repeat (100) @(negedge clk);
    check("ratio1_ticks100", longint'(ticks), 100);
    repeat (156) @(negedge clk);
    check("ticks_wrap", longint'(ticks), 0);

    // Ratio 4, then a mid-period switch to ratio 2.
    clk_choose = 3'd2;
    do_reset(3);
    wait_cpu_rst(n);
    check("release_latency2", n, 6);
    wait_pulse(n);
    check("ratio4_first", n, 4);
    clk_choose = 3'd1;
    wait_pulse(n);
    check("switch_keep4", n, 4);
    wait_pulse(n);
    check("switch_then2", n, 2);
    wait_pulse(n);
    check("switch_then2b", n, 2);
    check("switch_sel", longint'(sel_cur), 1);

    // Saturation of select 7 to MAX_SHIFT.
    clk_choose = 3'd7;
    do_reset(2);
    wait_cpu_rst(n);
    check("sat_sel", longint'(sel_cur), 4);
    wait_pulse(n);
    wait_pulse(n);
    check("sat_period", n, 16);

    // One-cycle reset mid-period.
    clk_choose = 3'd3;
    do_reset(2);
    wait_cpu_rst(n);
    wait_pulse(n);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_cpu_rst", longint'(cpu_rst), 0);
    check("midrst_ticks",   longint'(ticks), 0);
    check("midrst_clk_en",  longint'(clk_en), 0);
    @(negedge clk);
    rst = 1'b1;
    wait_cpu_rst(n);
    check("midrst_release", n, 6);
    wait_pulse(n);
    check("midrst_first", n, 8);

`ifdef STEP_EN
    // Single-step: three held presses give three pulses; exit restarts the divider.
    step_mode = 1'b1; step_btn = 1'b0; clk_choose = 3'd1;
    do_reset(4);
    wait_cpu_rst(n);
    repeat (5) @(negedge clk);
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      step_btn = 1'b1;
      repeat (10) begin @(negedge clk); if (clk_en) pulses++; end
      step_btn = 1'b0;
      repeat (10) begin @(negedge clk); if (clk_en) pulses++; end
    end
    check("step_pulses", pulses, 3);
    check("step_ticks", longint'(ticks), 3);
    step_mode = 1'b0;
    wait_pulse(n);
    check("step_resume_gap", n, 5);
    wait_pulse(n);
    check("step_resume_period", n, 2);
`else
    pulses = 0;
`endif

    // Randomised traffic, including step inputs and short resets.
    step_mode = 1'b0; step_btn = 1'b0;
    do_reset(2);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) clk_choose = SEL_W'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) step_mode = ~step_mode;
      if ($urandom_range(0, 7) == 0)  step_btn = ~step_btn;
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst = 1'b1;
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/clk_rst_gen.md
CLK_RST_GEN -- requirements
Module: clk_rst_gen

Interface
REQ-001 Parameter: SEL_W, 3, width of the clock-select input.
REQ-002 Parameter: MAX_SHIFT, 4, largest divide exponent; the divide ratio is 2^min(sel, MAX_SHIFT).
REQ-003 Parameter: RST_HOLD, 4, core clocks that cpu_rst stays low after the synchronised reset release.
REQ-004 Parameter: CNT_W, 32, width of the issued-enable counter.
REQ-005 Port: clk, input, 1, single system clock; all state on its rising edge.
REQ-006 Port: rst, input, 1, asynchronous active-low reset.
REQ-007 Port: clk_choose, input, SEL_W, asynchronous divide-exponent select.
REQ-008 Port: step_mode, input, 1, asynchronous single-step mode request.
REQ-009 Port: step_btn, input, 1, asynchronous single-step button, level.
REQ-010 Port: cpu_rst, output, 1, active-low core reset; asserts asynchronously, deasserts synchronously.
REQ-011 Port: clk_en, output, 1, registered one-cycle core clock-enable pulse.
REQ-012 Port: sel_cur, output, SEL_W, divide exponent currently applied after saturation.
REQ-013 Port: ticks, output, CNT_W, count of clk_en pulses issued since reset.

Function
REQ-014 The block SHALL pass rst through a two-flop synchroniser; assertion SHALL be asynchronous and deassertion SHALL be synchronous.
REQ-015 After the synchronised release, cpu_rst SHALL stay 0 for exactly RST_HOLD more clk cycles and then go to 1.
REQ-016 clk_en SHALL be 0 while cpu_rst is 0.
REQ-017 clk_choose, step_mode and step_btn SHALL each pass through a two-flop synchroniser before use.
REQ-018 The divider counter SHALL be 0 in the first cycle cpu_rst is 1; clk_en SHALL pulse in the cycle after the counter reaches ratio-1, and the counter SHALL then wrap to 0.
REQ-019 At ratio 1, clk_en SHALL be high every cycle, starting one cycle after cpu_rst rises.
REQ-020 A new synchronised select SHALL be latched into sel_cur only at cpu_rst release or in the cycle a wrap occurs; no shortened or stretched period is permitted.
REQ-021 A select value above MAX_SHIFT SHALL saturate to MAX_SHIFT in sel_cur.
REQ-022 ticks SHALL increment by 1 on every clk_en pulse and wrap from 2^CNT_W-1 to 0.
REQ-023 Asserting rst mid-operation SHALL immediately force cpu_rst=0, clk_en=0, clear ticks and the divider, and restart the REQ-015 hold sequence.

Reset
REQ-024 While rst=0, the outputs SHALL be: cpu_rst=0, clk_en=0, ticks=0, and sel_cur=0.
REQ-025 While rst=0, the divider counter, step state and all synchroniser flops SHALL be 0.

Configuration
REQ-026 With STEP_EN defined, and synchronised step_mode=1 with cpu_rst=1, the divider SHALL be held at 0.
REQ-027 In step mode, clk_en SHALL pulse exactly once, one cycle after each synchronised 0->1 edge of step_btn; holding the button SHALL give no further pulses.
REQ-028 When step_mode returns to 0, the divider SHALL restart from 0 and the select SHALL be re-latched.
REQ-029 An edge of step_btn in the same cycle step_mode drops SHALL be ignored.
REQ-030 Without STEP_EN, step_mode and step_btn SHALL be ignored and all step logic SHALL be absent.

Verification
REQ-031 rst low 10 cycles then high with RST_HOLD=4 -> cpu_rst rises exactly 6 cycles after release (2 sync + 4 hold); clk_en=0 throughout.
REQ-032 clk_choose=0 -> clk_en high every cycle from one cycle after cpu_rst rises; ticks=100 after 100 pulses.
REQ-033 clk_choose=2 -> clk_en pulses every 4 cycles; change to 1 mid-period -> current 4-cycle period completes, then 2-cycle periods follow.
REQ-034 clk_choose=7 with MAX_SHIFT=4 -> sel_cur=4 and clk_en period 16.
REQ-035 STEP_EN build: step_mode=1 and 3 button presses, each held 10 cycles -> exactly 3 clk_en pulses and ticks=3; step_mode=0 -> periodic pulses resume from a counter of 0.
REQ-036 rst pulsed low for 1 cycle mid-period with clk_choose=3 -> cpu_rst=0 and ticks=0 at once, then the full 6-cycle release sequence repeats.
